// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array datapath blocks.
//   DATA_W    : default lane width in bits
//   word_t    : one lane element
//   row_idx_w : index width for a row count, $clog2 with a floor of 1
package tpu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  // Width needed to index n rows; never less than one bit.
  function automatic int unsigned row_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deskew_lane.sv
// Fixed-depth delay line for one result lane of the deskew stage.
// Ports:
//   clk : clock
//   rst : synchronous active-low clear of every stage
//   d   : lane data in
//   q   : lane data delayed by D cycles (D=0 is a plain wire)
module deskew_lane #(
  parameter int unsigned D      = 1,
  parameter int unsigned DATA_W = tpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  if (D == 0) begin : g_wire
    // Clock and clear have no load on a zero-depth lane.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst;
    assign q = d;
  end else begin : g_shift
    logic [D-1:0][DATA_W-1:0] sr;

    // Free-running shift; no enable so unqualified data also moves through.
    always_ff @(posedge clk) begin
      if (!rst) begin
        sr <= '0;
      end else begin
        sr[0] <= d;
        for (int k = 1; k < int'(D); k++) begin
          sr[k] <= sr[k-1];
        end
      end
    end

    assign q = sr[D-1];
  end

endmodule

// File: rtl/deskew.sv
// Output alignment stage for the systolic array: undoes the lane stagger so
// all lanes of a result row appear together with one valid strobe.
// Optional feature macro: DESKEW_ROW_TRACK_EN enables the row counter that
// drives out_row/out_last; without it both are tied to 0.
// Ports:
//   clk       : clock
//   rst       : synchronous active-low reset
//   in_valid  : qualifies lane 0 of a row (lane i follows i cycles later)
//   data_in   : skewed lane data, MAX_DELAY lanes of DATA_W bits
//   data_out  : aligned row (top lane is combinational from data_in)
//   out_valid : aligned row present on data_out
//   out_row   : index of the row on data_out
//   out_last  : final row of a tile
//   busy      : an accepted row is still in the pipe
module deskew #(
  parameter  int unsigned MAX_DELAY = 256,
  parameter  int unsigned DATA_W    = tpu_pkg::DATA_W,
  parameter  int unsigned ROWS      = 256,
  localparam int unsigned ROW_W     = tpu_pkg::row_idx_w(ROWS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [MAX_DELAY-1:0][DATA_W-1:0] data_in,
  output logic [MAX_DELAY-1:0][DATA_W-1:0] data_out,
  output logic                            out_valid,
  output logic [ROW_W-1:0]                out_row,
  output logic                            out_last,
  output logic                            busy
);

  // Lane i arrives i cycles late, so it is held MAX_DELAY-1-i cycles.
  for (genvar i = 0; i < int'(MAX_DELAY); i++) begin : g_lane
    deskew_lane #(
      .D      (MAX_DELAY - 1 - i),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .d   (data_in[i]),
      .q   (data_out[i])
    );
  end

  // Valid pipe matching the lane-0 delay.
  if (MAX_DELAY > 1) begin : g_vpipe
    logic [MAX_DELAY-2:0] vpipe;

    always_ff @(posedge clk) begin
      if (!rst) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= in_valid;
        for (int k = 1; k < int'(MAX_DELAY) - 1; k++) begin
          vpipe[k] <= vpipe[k-1];
        end
      end
    end

    assign out_valid = vpipe[MAX_DELAY-2];

    // The output stage is the row being emitted, so it no longer counts.
    if (MAX_DELAY > 2) begin : g_busy
      assign busy = |vpipe[MAX_DELAY-3:0];
    end else begin : g_nobusy
      assign busy = 1'b0;
    end
  end else begin : g_novpipe
    assign out_valid = in_valid;
    assign busy      = 1'b0;
  end

`ifdef DESKEW_ROW_TRACK_EN
  logic [ROW_W-1:0] row_cnt;

  // Advances after every emitted row, wrapping at the tile size.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_cnt <= '0;
    end else if (out_valid) begin
      if (row_cnt == ROW_W'(ROWS - 1)) begin
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + ROW_W'(1);
      end
    end
  end

  assign out_row  = row_cnt;
  assign out_last = out_valid && (row_cnt == ROW_W'(ROWS - 1));
`else
  assign out_row  = '0;
  assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_deskew.sv
// Directed scoreboard bench for deskew (MAX_DELAY=4, ROWS=4) plus a
// single-lane instance (MAX_DELAY=1) exercised alongside it.
module tb_deskew;

  localparam int unsigned MD = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned RW = 2;

  typedef logic [MD-1:0][DW-1:0] row_t;

  typedef struct {
    int   cyc;
    row_t data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  row_t          data_in  = '0;
  row_t          data_out;
  logic          out_valid;
  logic [RW-1:0] out_row;
  logic          out_last;
  logic          busy;

  logic               in_valid1 = 1'b0;
  logic [0:0][DW-1:0] data_in1  = '0;
  logic [0:0][DW-1:0] data_out1;
  logic               out_valid1;
  logic [RW-1:0]      out_row1;
  logic               out_last1;
  logic               busy1;

  deskew #(.MAX_DELAY(MD), .DATA_W(DW), .ROWS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy)
  );

  deskew #(.MAX_DELAY(1), .DATA_W(DW), .ROWS(NR)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .data_in   (data_in1),
    .data_out  (data_out1),
    .out_valid (out_valid1),
    .out_row   (out_row1),
    .out_last  (out_last1),
    .busy      (busy1)
  );

  exp_t sb[$];
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_row    = 0;
  int   m_row1   = 0;
  logic hv[MD];
  row_t hr[MD];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic row_t mkrow(input int base, input int stride);
    row_t r;
    for (int i = 0; i < int'(MD); i++) r[i] = DW'(base + stride * i);
    return r;
  endfunction

  // One clock cycle: drive skewed stimulus, then check both DUTs mid-cycle.
  task automatic step(input bit v, input row_t row, input bit r);
    exp_t e;
    bit   ev;
    bit   eb;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = MD - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hr[k] = hr[k-1];
    end
    hv[0]    = v && r;
    hr[0]    = row;
    rst      = r;
    in_valid = v;
    for (int i = 0; i < int'(MD); i++) data_in[i] = hv[i] ? hr[i][i] : DW'($urandom);
    if (v && r) sb.push_back('{cyc: cyc + int'(MD) - 1, data: row});
    in_valid1   = 1'($urandom_range(0, 1));
    data_in1[0] = DW'($urandom);
    @(negedge clk);

    ev = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("out_valid", 128'(out_valid), 128'(ev));
    if (ev) begin
      e = sb.pop_front();
      chk("data_out", 128'(data_out), 128'(e.data));
`ifdef DESKEW_ROW_TRACK_EN
      chk("out_row", 128'(out_row), 128'(m_row));
      chk("out_last", 128'(out_last), 128'(m_row == int'(NR) - 1));
      if (r) m_row = (m_row + 1) % int'(NR);
`else
      chk("out_row", 128'(out_row), 128'(0));
      chk("out_last", 128'(out_last), 128'(0));
`endif
    end else begin
      chk("out_last_idle", 128'(out_last), 128'(0));
    end
    // Rows accepted one or two cycles ago are still inside the pipe.
    eb = 1'b0;
    foreach (sb[j]) if (sb[j].cyc < cyc + int'(MD) - 1) eb = 1'b1;
    chk("busy", 128'(busy), 128'(eb));

    chk("md1_valid", 128'(out_valid1), 128'(in_valid1));
    chk("md1_data", 128'(data_out1), 128'(data_in1));
    chk("md1_busy", 128'(busy1), 128'(0));
`ifdef DESKEW_ROW_TRACK_EN
    chk("md1_row", 128'(out_row1), 128'(m_row1));
    chk("md1_last", 128'(out_last1), 128'(in_valid1 && (m_row1 == int'(NR) - 1)));
    if (in_valid1 && r) m_row1 = (m_row1 + 1) % int'(NR);
`else
    chk("md1_row", 128'(out_row1), 128'(0));
    chk("md1_last", 128'(out_last1), 128'(0));
`endif

    if (!r) begin
      sb.delete();
      for (int k = 0; k < int'(MD); k++) hv[k] = 1'b0;
      m_row  = 0;
      m_row1 = 0;
    end
  endtask

  initial begin
    for (int k = 0; k < int'(MD); k++) begin
      hv[k] = 1'b0;
      hr[k] = '0;
    end

    // Reset, then confirm the cleared state on the first free cycle.
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("rst_lanes", 128'(data_out[MD-2:0]), 128'(0));
    chk("rst_top_lane", 128'(data_out[MD-1]), 128'(data_in[MD-1]));
    chk("rst_out_row", 128'(out_row), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));

    // Single row at cycle 10.
    while (cyc < 9) step(1'b0, '0, 1'b1);
    step(1'b1, mkrow(32'h10, 32'h10), 1'b1);
    chk("busy_inflight", 128'(busy), 128'(0));
    step(1'b0, '0, 1'b1);
    chk("busy_after_accept", 128'(busy), 128'(1));
    while (cyc < 15) step(1'b0, '0, 1'b1);

    // Restart the row count, then four back-to-back rows plus one to wrap.
    step(1'b0, '0, 1'b0);
    while (cyc < 19) step(1'b0, '0, 1'b1);
    for (int r = 0; r < 5; r++) step(1'b1, mkrow(r * 16, 1), 1'b1);
    while (cyc < 29) step(1'b0, '0, 1'b1);

    // Row at 30 killed by reset at 31.
    step(1'b1, mkrow(32'hA0, 1), 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("midrst_lanes", 128'(data_out[MD-2:0]), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    step(1'b0, '0, 1'b1);
    step(1'b1, mkrow(32'hB0, 3), 1'b1);
    while (cyc < 40) step(1'b0, '0, 1'b1);

    // Long idle stretch with garbage on the lanes.
    while (cyc < 60) step(1'b0, '0, 1'b1);
`ifdef DESKEW_ROW_TRACK_EN
    chk("idle_out_row", 128'(out_row), 128'(m_row));
`else
    chk("idle_out_row", 128'(out_row), 128'(0));
`endif
    chk("sb_drain", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
